// File: rtl/record_saver.sv
// Run-length recorder: captures synchronised keyboard codes as {key, duration} events
// into one of three RAM slots, with a registered read port for the playback block.
module record_saver #(
    parameter int TICK_DIV = 500000,
    parameter int DUR_W    = 8,
    parameter int DEPTH    = 64,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int WORD_W  = 7 + DUR_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              rec_btn_n,
    input  logic [2:0]        slot_sel,
    input  logic [6:0]        key_ascii,
    input  logic [1:0]        rd_slot,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic [ADDR_W:0]   len0,
    output logic [ADDR_W:0]   len1,
    output logic [ADDR_W:0]   len2,
    output logic              recording,
    output logic              full_err,
    output logic              sel_err
);

    localparam int CNT_W = $clog2(TICK_DIV + 1);
    localparam logic [DUR_W-1:0]  DUR_MAX   = '1;
    localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RECORD, FLUSH} state_t;

    // Input synchronisers; btn_s3_q holds the previous synced level for edge detection.
    logic             btn_s1_q, btn_s2_q, btn_s3_q;
    logic [2:0]       sel_s1_q, sel_s2_q;
    logic [6:0]       key_s1_q, key_s2_q;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [ADDR_W:0]  ptr_q, ptr_d;
    logic [6:0]       cur_key_q, cur_key_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W:0]  len_q [3];
    logic [ADDR_W:0]  len_d [3];
    logic             full_err_q, full_err_d;
    logic             sel_err_q, sel_err_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;

    logic              press, tick, sel_onehot, wr_en;
    logic [1:0]        sel_idx;
    logic [WORD_W-1:0] wr_data;
    logic [WORD_W-1:0] mem [3][DEPTH];

    assign press = btn_s3_q & ~btn_s2_q;
    assign tick  = (state_q == RECORD) && (cnt_q == CNT_LAST);

    always_comb begin
        sel_onehot = 1'b1;
        sel_idx    = 2'd0;
        case (sel_s2_q)
            3'b001:  sel_idx = 2'd0;
            3'b010:  sel_idx = 2'd1;
            3'b100:  sel_idx = 2'd2;
            default: sel_onehot = 1'b0;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        ptr_d      = ptr_q;
        cur_key_d  = cur_key_q;
        dur_d      = dur_q;
        cnt_d      = '0;
        len_d      = len_q;
        full_err_d = 1'b0;
        sel_err_d  = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        case (state_q)
            IDLE: begin
                if (press && sel_onehot) begin
                    state_d         = RECORD;
                    slot_d          = sel_idx;
                    len_d[sel_idx]  = '0;
                    ptr_d           = '0;
                    cur_key_d       = key_s2_q;
                    dur_d           = '0;
                end else if (press) begin
                    sel_err_d = 1'b1;
                end
            end
            RECORD: begin
                cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                if (press) begin
                    state_d = FLUSH;
                end else if (key_s2_q != cur_key_q) begin
                    wr_en     = 1'b1;
                    wr_data   = {cur_key_q, dur_q};
                    ptr_d     = ptr_q + (ADDR_W + 1)'(1);
                    cur_key_d = key_s2_q;
                    dur_d     = tick ? DUR_W'(1) : '0;
                end else if (tick && dur_q == DUR_MAX) begin
                    // Long note: emit a saturated event and keep counting the same key.
                    wr_en   = 1'b1;
                    wr_data = {cur_key_q, DUR_MAX};
                    ptr_d   = ptr_q + (ADDR_W + 1)'(1);
                    dur_d   = DUR_W'(1);
                end else if (tick) begin
                    dur_d = dur_q + DUR_W'(1);
                end
                if (wr_en && ptr_d == DEPTH_LEN) begin
                    len_d[slot_q] = DEPTH_LEN;
                    full_err_d    = 1'b1;
                    state_d       = IDLE;
                end
            end
            FLUSH: begin
                wr_en         = 1'b1;
                wr_data       = {cur_key_q, dur_q};
                len_d[slot_q] = ptr_q + (ADDR_W + 1)'(1);
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_slot != 2'd3) begin
            rd_data_d = mem[rd_slot][rd_addr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_s3_q   <= 1'b0;
            sel_s1_q   <= '0;
            sel_s2_q   <= '0;
            key_s1_q   <= '0;
            key_s2_q   <= '0;
            state_q    <= IDLE;
            slot_q     <= '0;
            ptr_q      <= '0;
            cur_key_q  <= '0;
            dur_q      <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < 3; i++) len_q[i] <= '0;
            full_err_q <= 1'b0;
            sel_err_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            btn_s1_q   <= rec_btn_n;
            btn_s2_q   <= btn_s1_q;
            btn_s3_q   <= btn_s2_q;
            sel_s1_q   <= slot_sel;
            sel_s2_q   <= sel_s1_q;
            key_s1_q   <= key_ascii;
            key_s2_q   <= key_s1_q;
            state_q    <= state_d;
            slot_q     <= slot_d;
            ptr_q      <= ptr_d;
            cur_key_q  <= cur_key_d;
            dur_q      <= dur_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            full_err_q <= full_err_d;
            sel_err_q  <= sel_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // NOTE: the RAM is deliberately not reset; zero lengths hide stale contents.
    always_ff @(posedge clock) begin
        if (wr_en && resetn) begin
            mem[slot_q][ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign rd_data   = rd_data_q;
    assign len0      = len_q[0];
    assign len1      = len_q[1];
    assign len2      = len_q[2];
    assign recording = (state_q == RECORD) || (state_q == FLUSH);
    assign full_err  = full_err_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_record_saver.sv
// Self-checking bench for record_saver with small parameters; RAM reads are scoreboarded.
module tb_record_saver;

    localparam int TICK_DIV = 4;
    localparam int DUR_W    = 4;
    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 2;

    logic              clock = 1'b0;
    logic              resetn;
    logic              rec_btn_n;
    logic [2:0]        slot_sel;
    logic [6:0]        key_ascii;
    logic [1:0]        rd_slot;
    logic [ADDR_W-1:0] rd_addr;
    logic [10:0]       rd_data;
    logic [ADDR_W:0]   len0, len1, len2;
    logic              recording, full_err, sel_err;

    int n_tests = 0;
    int n_fail  = 0;
    int full_cnt = 0;
    int sel_cnt  = 0;
    logic [10:0] exp_q [$];

    record_saver #(.TICK_DIV(TICK_DIV), .DUR_W(DUR_W), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .rec_btn_n (rec_btn_n),
        .slot_sel  (slot_sel),
        .key_ascii (key_ascii),
        .rd_slot   (rd_slot),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .len0      (len0),
        .len1      (len1),
        .len2      (len2),
        .recording (recording),
        .full_err  (full_err),
        .sel_err   (sel_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (full_err === 1'b1) full_cnt++;
        if (sel_err === 1'b1) sel_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic rd(input logic [1:0] s, input logic [ADDR_W-1:0] a, input logic [10:0] exp);
        rd_slot = s;
        rd_addr = a;
        exp_q.push_back(exp);
        wait_neg(1);
        check($sformatf("rd_data s%0d a%0d", s, a), rd_data, exp_q.pop_front());
    endtask

    task automatic lens(input string tag, input int l0, input int l1, input int l2);
        check({tag, " len0"}, len0, l0);
        check({tag, " len1"}, len1, l1);
        check({tag, " len2"}, len2, l2);
    endtask

    initial begin
        resetn    = 1'b0;
        rec_btn_n = 1'b1;
        slot_sel  = 3'b000;
        key_ascii = 7'h00;
        rd_slot   = 2'd0;
        rd_addr   = '0;
        wait_neg(3);
        check("reset rd_data", rd_data, 0);
        check("reset recording", recording, 0);
        check("reset full_err", full_err, 0);
        check("reset sel_err", sel_err, 0);
        lens("reset", 0, 0, 0);
        resetn = 1'b1;
        wait_neg(3);

        // Slot 1: 'a' for 13 FSM cycles (3 ticks), then a 6-cycle rest, then stop.
        slot_sel  = 3'b010;
        key_ascii = 7'h61;
        wait_neg(4);
        rec_btn_n = 1'b0;
        wait_neg(4);
        rec_btn_n = 1'b1;
        check("t1 recording", recording, 1);
        lens("t1 during", 0, 0, 0);
        wait_neg(9);
        key_ascii = 7'h00;
        wait_neg(6);
        rec_btn_n = 1'b0;
        wait_neg(4);
        rec_btn_n = 1'b1;
        check("t1 stopped", recording, 0);
        lens("t1 after", 0, 2, 0);
        rd(2'd1, 2'd0, {7'h61, 4'd3});
        rd(2'd1, 2'd1, {7'h00, 4'd1});

        // Slot 1 again: hold 'b' for 17 ticks -> saturated event plus remainder.
        key_ascii = 7'h62;
        wait_neg(4);
        rec_btn_n = 1'b0;
        wait_neg(4);
        rec_btn_n = 1'b1;
        lens("t2 during", 0, 0, 0);
        wait_neg(66);
        rec_btn_n = 1'b0;
        wait_neg(4);
        rec_btn_n = 1'b1;
        check("t2 stopped", recording, 0);
        lens("t2 after", 0, 2, 0);
        rd(2'd1, 2'd0, {7'h62, 4'd15});
        rd(2'd1, 2'd1, {7'h62, 4'd2});

        // Slot 2: key changes every 5 cycles until the slot fills.
        slot_sel  = 3'b100;
        key_ascii = 7'h63;
        wait_neg(4);
        rec_btn_n = 1'b0;
        wait_neg(4);
        rec_btn_n = 1'b1;
        wait_neg(1);
        key_ascii = 7'h64;
        wait_neg(5);
        key_ascii = 7'h65;
        wait_neg(5);
        key_ascii = 7'h66;
        wait_neg(5);
        key_ascii = 7'h67;
        wait_neg(3);
        check("t3 full_err", full_err, 1);
        check("t3 recording", recording, 0);
        check("t3 len2", len2, 4);
        wait_neg(1);
        check("t3 full_err low", full_err, 0);
        wait_neg(1);
        key_ascii = 7'h68;
        wait_neg(4);
        check("t3 still idle", recording, 0);
        check("t3 full pulses", full_cnt, 1);
        rd(2'd2, 2'd0, {7'h63, 4'd1});
        rd(2'd2, 2'd3, {7'h66, 4'd1});

        // Non-one-hot slot select.
        slot_sel = 3'b011;
        wait_neg(4);
        rec_btn_n = 1'b0;
        wait_neg(3);
        check("t4 sel_err", sel_err, 1);
        check("t4 recording", recording, 0);
        wait_neg(1);
        rec_btn_n = 1'b1;
        wait_neg(4);
        check("t4 sel pulses", sel_cnt, 1);
        check("t4 recording idle", recording, 0);
        lens("t4", 0, 2, 4);

        // Slot 0 record/stop, then slot 2 recording keeps len0.
        slot_sel  = 3'b001;
        key_ascii = 7'h78;
        wait_neg(4);
        rec_btn_n = 1'b0;
        wait_neg(4);
        rec_btn_n = 1'b1;
        wait_neg(6);
        rec_btn_n = 1'b0;
        wait_neg(4);
        rec_btn_n = 1'b1;
        lens("t5 slot0", 1, 2, 4);
        rd(2'd0, 2'd0, {7'h78, 4'd2});
        slot_sel = 3'b100;
        wait_neg(4);
        rec_btn_n = 1'b0;
        wait_neg(4);
        rec_btn_n = 1'b1;
        check("t5 recording", recording, 1);
        lens("t5 slot2 rec", 1, 2, 0);
        rd(2'd0, 2'd0, {7'h78, 4'd2});
        rd(2'd3, 2'd1, 11'h000);

        // Reset lands on the same edge as a key change: no write may happen.
        key_ascii = 7'h79;
        wait_neg(2);
        resetn = 1'b0;
        wait_neg(1);
        check("t6 recording", recording, 0);
        lens("t6 reset", 0, 0, 0);
        resetn = 1'b1;
        wait_neg(3);
        check("t6 still idle", recording, 0);
        rd(2'd2, 2'd0, {7'h63, 4'd1});
        rd(2'd0, 2'd0, {7'h78, 4'd2});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
